// File: rtl/apb_uart_scheduler_pkg.sv
// Shared APB definitions for the UART scheduler: slave register map,
// status bit positions, FSM/transfer encodings and a counter-width helper.
package apb_uart_scheduler_pkg;

  localparam logic [7:0] ADDR_TX_DATA = 8'h20;
  localparam logic [7:0] ADDR_RX_DATA = 8'h21;
  localparam logic [7:0] ADDR_STATUS  = 8'h22;

  localparam int STAT_T_BUSY = 0;
  localparam int STAT_R_STOP = 1;

  typedef enum logic [1:0] {
    ST_GAP    = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DECIDE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    XFER_STATUS = 2'd0,
    XFER_RX     = 2'd1,
    XFER_TX     = 2'd2
  } xfer_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_uart_scheduler_fifo.sv
// TX byte FIFO for the UART scheduler. Full/empty come from the registered
// count, so a byte pushed into an empty FIFO only becomes poppable next cycle
// and a push while full is dropped even if a pop happens in the same cycle.
module uart_tx_fifo
  import apb_uart_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic       ready_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int PW = cnt_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign ready_o = (count_q != CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && ready_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while the count says empty.
  always_ff @(posedge pclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/apb_uart_scheduler.sv
// APB master that polls a UART slave's STATUS register, fetches RX bytes on a
// new r_stop edge and drains the TX FIFO into TX_DATA while the slave is idle.
//
// state  | meaning
// GAP    | bus idle, poll-gap down-counter running; at 0 issue a STATUS read
// SETUP  | APB setup phase for the selected transfer (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or the access timeout
// DECIDE | one cycle choosing RX read, TX write or back to GAP
module apb_uart_scheduler
  import apb_uart_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_GAP   = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  output logic       timeout_err,
  input  logic       clear_err
);

  localparam int GW = cnt_width(POLL_GAP);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  xfer_e         xfer_q, xfer_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    paddr_q, paddr_d;
  logic [7:0]    pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          err_q, err_d;
  logic          t_busy_q, t_busy_d;
  logic          r_stop_q, r_stop_d;
  logic          r_stop_prev_q, r_stop_prev_d;
  logic          to_set;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .pclk        (pclk),
    .presetn     (presetn),
    .push_i      (tx_valid),
    .push_data_i (tx_data),
    .pop_i       (fifo_pop),
    .ready_o     (tx_ready),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign timeout_err = err_q;

  // Next-state, transfer selection, completion handling and timers.
  always_comb begin
    state_d       = state_q;
    xfer_d        = xfer_q;
    gap_cnt_d     = gap_cnt_q;
    to_cnt_d      = to_cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    t_busy_d      = t_busy_q;
    r_stop_d      = r_stop_q;
    r_stop_prev_d = r_stop_prev_q;
    to_set        = 1'b0;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d  = ST_SETUP;
          xfer_d   = XFER_STATUS;
          paddr_d  = ADDR_STATUS;
          pwrite_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        to_cnt_d = TO_LOAD;
      end
      ST_ACCESS: begin
        if (pready) begin
          case (xfer_q)
            XFER_STATUS: begin
              state_d       = ST_DECIDE;
              t_busy_d      = prdata[STAT_T_BUSY];
              r_stop_d      = prdata[STAT_R_STOP];
              r_stop_prev_d = r_stop_q;
            end
            XFER_RX: begin
              state_d    = ST_GAP;
              gap_cnt_d  = GAP_LOAD;
              rx_data_d  = prdata;
              rx_valid_d = 1'b1;
            end
            default: begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
              fifo_pop  = 1'b1;
            end
          endcase
        end else if (to_cnt_q == '0) begin
          // Abandon the transfer; a TX byte stays at the FIFO head for retry.
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
          to_set    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end
      ST_DECIDE: begin
        if (r_stop_q && !r_stop_prev_q) begin
          state_d  = ST_SETUP;
          xfer_d   = XFER_RX;
          paddr_d  = ADDR_RX_DATA;
          pwrite_d = 1'b0;
        end else if (!t_busy_q && !fifo_empty) begin
          state_d  = ST_SETUP;
          xfer_d   = XFER_TX;
          paddr_d  = ADDR_TX_DATA;
          pwrite_d = 1'b1;
          pwdata_d = fifo_head;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      default: begin
        state_d   = ST_GAP;
        gap_cnt_d = GAP_LOAD;
      end
    endcase

    err_d = clear_err ? 1'b0 : (err_q | to_set);
  end

  // State and datapath registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_GAP;
      xfer_q        <= XFER_STATUS;
      gap_cnt_q     <= GAP_LOAD;
      to_cnt_q      <= TO_LOAD;
      paddr_q       <= 8'h00;
      pwdata_q      <= 8'h00;
      pwrite_q      <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      err_q         <= 1'b0;
      t_busy_q      <= 1'b0;
      r_stop_q      <= 1'b0;
      r_stop_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      xfer_q        <= xfer_d;
      gap_cnt_q     <= gap_cnt_d;
      to_cnt_q      <= to_cnt_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      err_q         <= err_d;
      t_busy_q      <= t_busy_d;
      r_stop_q      <= r_stop_d;
      r_stop_prev_q <= r_stop_prev_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_scheduler.sv
// Bench for apb_uart_scheduler: an APB slave model answers STATUS/RX reads
// from a script, and scoreboards of expected TX writes and RX bytes are
// filled as stimulus is driven and drained as the DUT produces them.
module tb_apb_uart_scheduler;

  localparam int POLL_GAP = 8;
  localparam int TIMEOUT  = 16;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b0;
  logic       clear_err = 1'b0;
  logic       tx_ready, rx_valid, psel, penable, pwrite, timeout_err;
  logic [7:0] rx_data, paddr, pwdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp_wr[$];
  logic [7:0] exp_rx[$];
  logic [7:0] status_script[$];
  logic [7:0] rx_byte = 8'h3C;
  logic [7:0] last_status = 8'h00;
  int stall_wr = 0;
  int stall_any = 0;
  int n_writes = 0;
  int n_status = 0;
  int n_rx_reads = 0;
  int n_rx_pulses = 0;
  int wr_done_cyc = 0;
  int writes_at_rx = 0;

  apb_uart_scheduler #(
    .FIFO_DEPTH (4),
    .POLL_GAP   (POLL_GAP),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .timeout_err (timeout_err),
    .clear_err   (clear_err)
  );

  initial forever #5 pclk = ~pclk;

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // Slave model and output monitor, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge pclk);
      if (rx_valid) begin
        n_rx_pulses++;
        n_checks++;
        if (exp_rx.size() == 0) begin
          n_errors++;
          $display("FAIL rx_pulse: unexpected rx_valid with rx_data=%02h, required no pulse", rx_data);
        end else begin
          if (rx_data !== exp_rx[0]) begin
            n_errors++;
            $display("FAIL rx_data: got %02h required %02h", rx_data, exp_rx[0]);
          end
          void'(exp_rx.pop_front());
        end
      end
      pready = 1'b0;
      if (presetn && psel && penable) begin
        if (stall_any > 0) stall_any--;
        else if (pwrite && stall_wr > 0) stall_wr--;
        else begin
          pready = 1'b1;
          if (pwrite) begin
            n_writes++;
            wr_done_cyc = cyc + 1;
            n_checks++;
            if (exp_wr.size() == 0) begin
              n_errors++;
              $display("FAIL tx_write: unexpected write pwdata=%02h, required none", pwdata);
            end else begin
              if (pwdata !== exp_wr[0] || paddr !== 8'h20 || last_status[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL tx_write: paddr=%02h pwdata=%02h last_status=%02h, required paddr=20 pwdata=%02h t_busy=0",
                         paddr, pwdata, last_status, exp_wr[0]);
              end
              void'(exp_wr.pop_front());
            end
          end else if (paddr === 8'h22) begin
            prdata = (status_script.size() != 0) ? status_script.pop_front() : 8'h00;
            last_status = prdata;
            n_status++;
          end else if (paddr === 8'h21) begin
            prdata = rx_byte;
            exp_rx.push_back(rx_byte);
            n_rx_reads++;
            writes_at_rx = n_writes;
          end else begin
            n_checks++;
            n_errors++;
            $display("FAIL apb_addr: read of paddr=%02h, required 21 or 22", paddr);
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int budget = 300;
    @(negedge pclk);
    while (!tx_ready && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    tx_valid = 1'b1;
    tx_data  = b;
    if (tx_ready) exp_wr.push_back(b);
    @(negedge pclk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_writes(input int target, output bit ok);
    int budget = 2000;
    while (n_writes < target && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    ok = (n_writes >= target);
  endtask

  task automatic wait_psel(input logic level, output bit ok);
    int budget = 500;
    while (psel !== level && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    ok = (psel === level);
  endtask

  task automatic test_reset;
    logic [29:0] got;
    int rel;
    bit ok;
    repeat (3) @(negedge pclk);
    got = {tx_ready, psel, penable, pwrite, rx_valid, timeout_err, paddr, pwdata, rx_data};
    n_checks++;
    if (got !== 30'h2000_0000) begin
      n_errors++;
      $display("FAIL reset_values: got %08h required 20000000", got);
    end
    presetn = 1'b1;
    rel = cyc;
    wait_psel(1'b1, ok);
    n_checks++;
    if (!ok || (cyc - rel) != POLL_GAP || paddr !== 8'h22 || pwrite !== 1'b0 || penable !== 1'b0) begin
      n_errors++;
      $display("FAIL first_poll: ok=%0d delay=%0d paddr=%02h pwrite=%b penable=%b, required delay=%0d paddr=22 pwrite=0 penable=0",
               ok, cyc - rel, paddr, pwrite, penable, POLL_GAP);
    end
  endtask

  task automatic test_single_tx;
    int w0;
    bit ok, ok2;
    w0 = n_writes;
    push_byte(8'hA5);
    wait_writes(w0 + 1, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL single_write: writes=%0d required %0d", n_writes - w0, 1);
    end
    wait_psel(1'b0, ok);
    wait_psel(1'b1, ok2);
    n_checks++;
    if (!ok2 || (cyc - wr_done_cyc) != POLL_GAP || paddr !== 8'h22) begin
      n_errors++;
      $display("FAIL poll_gap: gap=%0d paddr=%02h required gap=%0d paddr=22", cyc - wr_done_cyc, paddr, POLL_GAP);
    end
    repeat (40) @(negedge pclk);
    n_checks++;
    if (n_writes !== w0 + 1 || tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL single_pop: writes=%0d tx_ready=%b required writes=1 tx_ready=1", n_writes - w0, tx_ready);
    end
  endtask

  task automatic test_fill_busy;
    int w0, s0;
    bit ok;
    status_script = '{8'h01, 8'h01, 8'h01};
    w0 = n_writes;
    s0 = n_status;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    n_checks++;
    if (tx_ready !== 1'b0 || n_writes !== w0) begin
      n_errors++;
      $display("FAIL fifo_full: tx_ready=%b writes=%0d required tx_ready=0 writes=0", tx_ready, n_writes - w0);
    end
    @(negedge pclk);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    @(negedge pclk);
    tx_valid = 1'b0;
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL push_full: tx_ready=%b required 0", tx_ready);
    end
    wait_writes(w0 + 4, ok);
    repeat (30) @(negedge pclk);
    n_checks++;
    if (!ok || n_writes !== w0 + 4 || exp_wr.size() != 0 || (n_status - s0) < 7) begin
      n_errors++;
      $display("FAIL busy_drain: writes=%0d pending=%0d polls=%0d required writes=4 pending=0 polls>=7",
               n_writes - w0, exp_wr.size(), n_status - s0);
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_ready: tx_ready=%b required 1", tx_ready);
    end
  endtask

  task automatic test_rx_priority;
    int w0, r0, p0;
    bit ok;
    rx_byte = 8'h3C;
    status_script = '{8'h02, 8'h02};
    w0 = n_writes;
    r0 = n_rx_reads;
    p0 = n_rx_pulses;
    push_byte(8'h77);
    wait_writes(w0 + 1, ok);
    n_checks++;
    if (!ok || n_rx_reads !== r0 + 1 || writes_at_rx !== w0) begin
      n_errors++;
      $display("FAIL rx_first: ok=%0d rx_reads=%0d writes_before_rx=%0d required rx_reads=1 writes_before_rx=0",
               ok, n_rx_reads - r0, writes_at_rx - w0);
    end
    repeat (40) @(negedge pclk);
    n_checks++;
    if (n_rx_reads !== r0 + 1 || n_rx_pulses !== p0 + 1 || exp_rx.size() != 0) begin
      n_errors++;
      $display("FAIL rx_once: rx_reads=%0d pulses=%0d pending=%0d required 1 1 0",
               n_rx_reads - r0, n_rx_pulses - p0, exp_rx.size());
    end
    n_checks++;
    if (rx_data !== 8'h3C) begin
      n_errors++;
      $display("FAIL rx_hold: rx_data=%02h required 3c", rx_data);
    end
  endtask

  task automatic test_timeout;
    int w0, budget;
    bit ok;
    logic saw_err;
    w0 = n_writes;
    stall_wr = TIMEOUT;
    push_byte(8'h55);
    budget = 500;
    while (timeout_err !== 1'b1 && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    n_checks++;
    if (timeout_err !== 1'b1 || psel !== 1'b0 || penable !== 1'b0 || n_writes !== w0) begin
      n_errors++;
      $display("FAIL timeout_abort: err=%b psel=%b penable=%b writes=%0d required 1 0 0 0",
               timeout_err, psel, penable, n_writes - w0);
    end
    wait_writes(w0 + 1, ok);
    n_checks++;
    if (!ok || exp_wr.size() != 0 || timeout_err !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_retry: ok=%0d pending=%0d err=%b required ok=1 pending=0 err=1",
               ok, exp_wr.size(), timeout_err);
    end
    @(negedge pclk);
    clear_err = 1'b1;
    @(negedge pclk);
    clear_err = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_err: err=%b required 0", timeout_err);
    end
    clear_err = 1'b1;
    stall_wr = TIMEOUT;
    saw_err = 1'b0;
    push_byte(8'h6B);
    repeat (80) begin
      @(negedge pclk);
      saw_err = saw_err | timeout_err;
    end
    clear_err = 1'b0;
    wait_writes(w0 + 2, ok);
    n_checks++;
    if (saw_err !== 1'b0 || !ok || stall_wr != 0) begin
      n_errors++;
      $display("FAIL clear_priority: saw_err=%b ok=%0d stall_left=%0d required 0 1 0", saw_err, ok, stall_wr);
    end
    stall_wr = TIMEOUT - 1;
    push_byte(8'h5A);
    wait_writes(w0 + 3, ok);
    n_checks++;
    if (!ok || timeout_err !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_edge: ok=%0d err=%b required ok=1 err=0", ok, timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    logic [29:0] got;
    int w0, budget;
    bit ok;
    status_script = '{8'h01, 8'h01, 8'h01, 8'h01};
    stall_any = 100;
    push_byte(8'h11);
    push_byte(8'h22);
    budget = 200;
    while (!(psel === 1'b1 && penable === 1'b1) && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    repeat (2) @(negedge pclk);
    n_checks++;
    if (penable !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_access: penable=%b required 1", penable);
    end
    presetn = 1'b0;
    #1;
    got = {tx_ready, psel, penable, pwrite, rx_valid, timeout_err, paddr, pwdata, rx_data};
    n_checks++;
    if (got !== 30'h2000_0000) begin
      n_errors++;
      $display("FAIL reset_mid_values: got %08h required 20000000", got);
    end
    exp_wr.delete();
    exp_rx.delete();
    status_script.delete();
    stall_any = 0;
    @(negedge pclk);
    presetn = 1'b1;
    w0 = n_writes;
    repeat (60) @(negedge pclk);
    n_checks++;
    if (n_writes !== w0 || tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_discard: writes=%0d tx_ready=%b required 0 1", n_writes - w0, tx_ready);
    end
    push_byte(8'h33);
    wait_writes(w0 + 1, ok);
    n_checks++;
    if (!ok || exp_wr.size() != 0) begin
      n_errors++;
      $display("FAIL post_reset_write: ok=%0d pending=%0d required 1 0", ok, exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_fill_busy();
    test_rx_priority();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_uart_scheduler.md
APB_UART_SCHEDULER -- requirements
Module: apb_uart_scheduler

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, TX byte FIFO entries (power of 2); POLL_GAP, default 8, idle cycles between APB transactions; TIMEOUT, default 16, maximum ACCESS cycles awaiting pready.
REQ-002 pclk  in  1  clock; all logic rising-edge.
REQ-003 presetn  in  1  reset, asynchronous, active-low.
REQ-004 tx_valid  in  1  client offers a TX byte.
REQ-005 tx_data  in  8  TX byte.
REQ-006 tx_ready  out  1  FIFO not full; a byte is pushed when tx_valid & tx_ready.
REQ-007 rx_valid  out  1  one-cycle pulse, rx_data valid.
REQ-008 rx_data  out  8  received byte, held until the next rx_valid.
REQ-009 psel, penable, pwrite  out  1 each  APB master controls.
REQ-010 paddr  out  8  APB address.
REQ-011 pwdata  out  8  APB write data.
REQ-012 prdata  in  8  APB read data.
REQ-013 pready  in  1  APB transfer complete.
REQ-014 timeout_err  out  1  sticky APB timeout flag.
REQ-015 clear_err  in  1  clears timeout_err (takes priority over a same-cycle set).

Function
REQ-016 Slave map SHALL be TX_DATA 0x20 (write), RX_DATA 0x21 (read), STATUS 0x22 (read; bit0 t_busy, bit1 r_stop).
REQ-017 FSM states SHALL be GAP, SETUP, ACCESS, DECIDE; reset state GAP.
REQ-018 GAP: down-counter loaded with POLL_GAP-1 on entry; at 0 -> SETUP issuing a STATUS read.
REQ-019 SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven for the selected transfer; always -> ACCESS next cycle.
REQ-020 ACCESS: psel=1, penable=1, address/data held stable; ends on the first cycle pready=1 (prdata sampled that cycle).
REQ-021 STATUS completion -> DECIDE; RX_DATA or TX_DATA completion -> GAP.
REQ-022 DECIDE (one cycle) priority: r_stop rising versus previous STATUS sample -> RX_DATA read; else t_busy=0 and FIFO non-empty -> TX_DATA write of FIFO head; else -> GAP.
REQ-023 RX_DATA completion SHALL set rx_data=prdata and pulse rx_valid the following cycle.
REQ-024 FIFO head SHALL pop only on a completed TX_DATA write; pwdata = head captured at SETUP.
REQ-025 Timeout: ACCESS cycle counter; if TIMEOUT cycles elapse without pready, drop psel/penable, set timeout_err, -> GAP; no pop, no rx_valid; the aborted TX byte is retried later.
REQ-026 psel/penable SHALL be 0 in GAP and DECIDE; at most one transfer outstanding.
REQ-027 FIFO: count 0..FIFO_DEPTH with wrapping pointers; tx_ready = (count != FIFO_DEPTH) from the registered count; a push while full is ignored even when a pop occurs that cycle; a push into an empty FIFO is not poppable until the next cycle; a simultaneous push and pop leaves count unchanged.
REQ-028 The previous r_stop sample SHALL update only on STATUS completion; reset value 0.

Reset
REQ-029 presetn low SHALL force: state GAP with counter reloaded, FIFO empty, tx_ready=1, psel=penable=pwrite=0, paddr=pwdata=0x00, rx_valid=0, rx_data=0x00, timeout_err=0, r_stop history 0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no pop and no rx_valid; queued FIFO bytes are discarded.

Structure
REQ-031 The slave address constants (0x20/0x21/0x22), status bit indices, and FSM state encoding SHALL reside in the shared APB package.
REQ-032 FIFO SHALL be a sub-module, uart_tx_fifo; the FSM, timers and APB drive SHALL be in the top.

Verification
REQ-033 Push 0xA5 with slave idle (status 0x00) -> STATUS read, then TX_DATA write pwdata=0xA5, then one pop; the next poll follows POLL_GAP cycles later.
REQ-034 Push 4 bytes 0x01..0x04 with status 0x01 for 3 polls then 0x00 -> tx_ready=0 after the 4th push, no writes while busy, then writes in order 0x01..0x04.
REQ-035 Status returns 0x02 after prior 0x00 with a TX byte pending -> RX_DATA read first; prdata 0x3C gives rx_valid pulse with rx_data=0x3C; a repeated 0x02 does not trigger a second read.
REQ-036 pready held low 16 cycles during TX_DATA 0x55 -> timeout_err=1, bus released, byte 0x55 retried and popped after a pready-responding transfer; clear_err -> 0.
REQ-037 presetn pulsed low during ACCESS with 2 bytes queued -> all outputs at reset values, tx_ready=1, no further writes until new pushes.
